issue_stage: RTL and testbench
==============================

ISSUE_STAGE -- requirements
Module: issue_stage

Interface
REQ-001 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset, sampled on the rising edge of clock.
REQ-003 SHALL have port in_valid, input, 1, the instruction pair from fetch is meaningful this cycle.
REQ-004 SHALL have port first_inst, input, [0:31], the instruction at pc_in.
REQ-005 SHALL have port second_inst, input, [0:31], the instruction at pc_in+4.
REQ-006 SHALL have port pc_in, input, [0:31], the byte address of first_inst.
REQ-007 SHALL have port flush, input, 1, branch taken; discard all in-flight and held work.
REQ-008 SHALL have port hold, input, 1, downstream back-pressure; freeze all state.
REQ-009 SHALL have port stall, output, 1, combinational; tells fetch to re-present the same pair next cycle.
REQ-010 SHALL have ports even_inst, odd_inst, output, [0:31] each, registered instructions issued to the even and odd pipes.
REQ-011 SHALL have ports even_pc, odd_pc, output, [0:31] each, registered address of each issued instruction.
REQ-012 SHALL have ports even_valid, odd_valid, output, 1 each, registered qualifiers for each pipe slot.

Function
REQ-013 SHALL classify each instruction as EVEN, ODD or NOP using the descriptions package pipe-class function on bits [0:10].
REQ-014 SHALL treat opcode [0:10]=11'b00000000001 as NOP regardless of the remaining bits, including X.
REQ-015 SHALL mark the pair as split-needed when both instructions are EVEN or both are ODD.
REQ-016 SHALL also mark split-needed on RAW: first writes rt (package writes-rt flag) and first[25:31] equals second[11:17] or second[18:24].
REQ-017 SHALL treat a pair containing a NOP as never split-needed.
REQ-018 SHALL implement a two-state FSM: PAIR and SPLIT.
REQ-019 In PAIR with in_valid=1 and no split needed, SHALL issue each non-NOP instruction to its class pipe on the next edge, in either slot order; pipes with nothing to issue get valid=0.
REQ-020 In PAIR with in_valid=1 and split needed, SHALL combinationally assert stall, issue only first_inst to its pipe, latch second_inst and pc_in+4 into a hold register, and go to SPLIT.
REQ-021 In SPLIT, SHALL ignore the inputs, issue the held instruction to its pipe with its held pc, keep stall=0, and return to PAIR.
REQ-022 SHALL issue at most one instruction per pipe per cycle and keep program order; the held second never issues before its first.
REQ-023 In PAIR with in_valid=0, SHALL drive both valids to 0 on the next edge with stall=0.
REQ-024 While hold=1, SHALL keep state, hold register and all outputs unchanged and assert stall; hold takes priority over split logic.
REQ-025 On flush=1, SHALL clear both valids and the hold register, go to PAIR on the next edge, and drive stall=0; flush takes priority over hold.
REQ-026 SHALL compute pc arithmetic modulo 2^32 (pc_in+4 wraps).
REQ-027 SHALL drive even_pc/odd_pc to 0 and even_inst/odd_inst to 0 whenever the corresponding valid is 0.

Reset
REQ-028 When reset=1 at an edge, SHALL enter PAIR, clear the hold register, and drive all registered outputs to 0.
REQ-029 SHALL drive stall=0 during reset; reset takes priority over flush and hold.
REQ-030 Reset asserted while in SPLIT SHALL discard the held instruction, which is never issued.

Verification
REQ-031 Pair E=a(00011000000), O=lqd, pc_in=0x100 -> next cycle even_pc=0x100, odd_pc=0x104, both valid, stall=0.
REQ-032 Pair of two EVEN instructions at 0x200 -> stall=1 for one cycle; cycle 1 even_pc=0x200; cycle 2 even_pc=0x204; odd_valid=0 in both.
REQ-033 EVEN writing rt=5, then ODD reading ra=5, at 0x300 -> split: even issues at 0x300, odd issues at 0x304 one cycle later.
REQ-034 first_inst=NOP filler, second_inst=ODD, pc_in=0x408 -> odd_pc=0x40C valid, even_valid=0, no stall.
REQ-035 flush asserted in SPLIT -> next cycle both valids 0, held instruction dropped, state PAIR; hold=1 for 3 cycles freezes outputs with stall=1.
REQ-036 pc_in=0xFFFFFFFC with split needed -> second issues with pc 0x00000000.

Source files
------------

// File: rtl/issue_stage.sv
// issue_stage: dual-issue of a fetched pair to even/odd pipes, splitting on pipe conflict or RAW
module issue_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [0:31] first_inst,
  input  logic [0:31] second_inst,
  input  logic [0:31] pc_in,
  input  logic        flush,
  input  logic        hold,
  output logic        stall,
  output logic [0:31] even_inst,
  output logic [0:31] odd_inst,
  output logic [0:31] even_pc,
  output logic [0:31] odd_pc,
  output logic        even_valid,
  output logic        odd_valid
);
  typedef enum logic [1:0] {NOP, EVEN, ODD} pclass_t;
  typedef enum logic {PAIR, SPLIT} state_t;
  // Opcode bit 2 selects the odd pipe (loads, stores); the all-zero-but-last opcode is the filler
  function automatic pclass_t pipe_class(input logic [0:10] op);
    return (op == 11'b00000000001) ? NOP : op[2] ? ODD : EVEN;
  endfunction
  // Stores (opcode prefix 0010) read rt rather than writing it
  function automatic logic writes_rt(input logic [0:10] op);
    return pipe_class(op) != NOP && op[0:3] != 4'b0010;
  endfunction
  state_t      state;
  logic [0:31] held_inst, held_pc;
  pclass_t     c1, c2, ch;
  logic        split, go_split;
  logic        ev_n, ov_n;
  logic [0:31] ei_n, ep_n, oi_n, op_n;
  assign c1 = pipe_class(first_inst[0:10]);
  assign c2 = pipe_class(second_inst[0:10]);
  assign ch = pipe_class(held_inst[0:10]);
  assign split = (c1 == NOP || c2 == NOP) ? 1'b0 :
                 (c1 == c2) || (writes_rt(first_inst[0:10]) &&
                 (first_inst[25:31] == second_inst[11:17] || first_inst[25:31] == second_inst[18:24]));
  assign go_split = state == PAIR && in_valid && split;
  assign stall = !reset && !flush && (hold || go_split);
  always_comb begin
    {ev_n, ei_n, ep_n, ov_n, oi_n, op_n} = '0;
    if (state == SPLIT) begin
      if (ch == EVEN) {ev_n, ei_n, ep_n} = {1'b1, held_inst, held_pc};
      if (ch == ODD) {ov_n, oi_n, op_n} = {1'b1, held_inst, held_pc};
    end else if (in_valid) begin
      if (c1 == EVEN) {ev_n, ei_n, ep_n} = {1'b1, first_inst, pc_in};
      if (c1 == ODD) {ov_n, oi_n, op_n} = {1'b1, first_inst, pc_in};
      if (!split && c2 == EVEN) {ev_n, ei_n, ep_n} = {1'b1, second_inst, pc_in + 32'd4};
      if (!split && c2 == ODD) {ov_n, oi_n, op_n} = {1'b1, second_inst, pc_in + 32'd4};
    end
  end
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state <= PAIR;
      held_inst <= '0;
      held_pc <= '0;
      {even_valid, even_inst, even_pc, odd_valid, odd_inst, odd_pc} <= '0;
    end else if (!hold) begin
      {even_valid, even_inst, even_pc, odd_valid, odd_inst, odd_pc} <= {ev_n, ei_n, ep_n, ov_n, oi_n, op_n};
      state <= go_split ? SPLIT : PAIR;
      if (go_split) begin
        held_inst <= second_inst;
        held_pc <= pc_in + 32'd4;
      end
    end
  end
endmodule

// File: tb/tb_issue_stage.sv
// tb_issue_stage: directed and random checks of issue_stage against a queue-based pairing model
module tb_issue_stage;
  logic        clock = 0, reset, in_valid, flush, hold;
  logic [0:31] first_inst, second_inst, pc_in;
  logic        stall, even_valid, odd_valid;
  logic [0:31] even_inst, odd_inst, even_pc, odd_pc;

  issue_stage dut (
    .clock(clock), .reset(reset), .in_valid(in_valid),
    .first_inst(first_inst), .second_inst(second_inst), .pc_in(pc_in),
    .flush(flush), .hold(hold), .stall(stall),
    .even_inst(even_inst), .odd_inst(odd_inst), .even_pc(even_pc), .odd_pc(odd_pc),
    .even_valid(even_valid), .odd_valid(odd_valid)
  );

  always #5 clock = ~clock;

  // Opcode table: a, sf, lqd, stqd, nop; class 0=nop 1=even 2=odd
  localparam logic [10:0] OPS [5] = '{11'b00011000000, 11'b00001000000, 11'b00110100000,
                                      11'b00100100000, 11'b00000000001};
  localparam int CLS [5] = '{1, 1, 2, 2, 0};
  localparam bit WRT [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

  typedef struct { logic [31:0] i, p; } slot_t;
  slot_t       m_q[$];
  logic        m_ev, m_ov, m_st;
  logic [31:0] m_ei, m_ep, m_oi, m_op;
  int          n_chk = 0, n_fail = 0;

  function automatic int kind(input logic [0:31] i);
    for (int k = 0; k < 5; k++) if (i[0:10] === OPS[k]) return k;
    return 4;
  endfunction

  function automatic logic [0:31] mk(input int k, input int rb, input int ra, input int rt);
    return {OPS[k], 7'(rb), 7'(ra), 7'(rt)};
  endfunction

  function automatic bit need_split(input logic [0:31] f, input logic [0:31] s);
    int kf = kind(f), ks = kind(s);
    if (CLS[kf] == 0 || CLS[ks] == 0) return 0;
    if (CLS[kf] == CLS[ks]) return 1;
    return WRT[kf] && (f[25:31] == s[11:17] || f[25:31] == s[18:24]);
  endfunction

  task automatic place(input logic [0:31] i, input logic [31:0] p);
    if (CLS[kind(i)] == 1) begin m_ev = 1; m_ei = i; m_ep = p; end
    if (CLS[kind(i)] == 2) begin m_ov = 1; m_oi = i; m_op = p; end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string nm, input logic rst, input logic fl, input logic hd, input logic iv,
                      input logic [0:31] f, input logic [0:31] s, input logic [31:0] pc);
    reset = rst; flush = fl; hold = hd; in_valid = iv;
    first_inst = f; second_inst = s; pc_in = pc;
    m_st = !rst && !fl && (hd || (m_q.size() == 0 && iv && need_split(f, s)));
    #2 chk({nm, ".stall"}, 32'(stall), 32'(m_st));
    if (rst || fl) begin
      m_q.delete();
      {m_ev, m_ei, m_ep, m_ov, m_oi, m_op} = '0;
    end else if (!hd) begin
      {m_ev, m_ei, m_ep, m_ov, m_oi, m_op} = '0;
      if (m_q.size() != 0) begin
        slot_t h = m_q.pop_front();
        place(h.i, h.p);
      end else if (iv) begin
        place(f, pc);
        if (need_split(f, s)) m_q.push_back('{s, pc + 32'd4});
        else place(s, pc + 32'd4);
      end
    end
    @(posedge clock);
    #1;
    chk({nm, ".even_valid"}, 32'(even_valid), 32'(m_ev));
    chk({nm, ".even_inst"}, even_inst, m_ei);
    chk({nm, ".even_pc"}, even_pc, m_ep);
    chk({nm, ".odd_valid"}, 32'(odd_valid), 32'(m_ov));
    chk({nm, ".odd_inst"}, odd_inst, m_oi);
    chk({nm, ".odd_pc"}, odd_pc, m_op);
  endtask

  initial begin
    logic [0:31] xn;
    {m_ev, m_ei, m_ep, m_ov, m_oi, m_op} = '0;
    @(posedge clock);
    #1;
    step("reset", 1, 0, 0, 1, mk(0, 1, 2, 3), mk(1, 4, 5, 6), 32'h0);
    step("pair_eo", 0, 0, 0, 1, mk(0, 2, 1, 3), mk(2, 0, 7, 9), 32'h100);
    step("two_even", 0, 0, 0, 1, mk(0, 1, 2, 3), mk(1, 4, 5, 6), 32'h200);
    step("two_even_2nd", 0, 0, 0, 1, mk(2, 0, 1, 2), mk(3, 0, 1, 2), 32'h250);
    step("raw", 0, 0, 0, 1, mk(0, 1, 2, 5), mk(2, 0, 5, 6), 32'h300);
    step("raw_2nd", 0, 0, 0, 0, mk(0, 1, 2, 5), mk(2, 0, 5, 6), 32'h300);
    step("nop_first", 0, 0, 0, 1, mk(4, 1, 2, 3), mk(2, 0, 1, 2), 32'h408);
    step("store_no_raw", 0, 0, 0, 1, mk(3, 0, 1, 2), mk(0, 2, 3, 4), 32'h410);
    step("split_pre", 0, 0, 0, 1, mk(1, 1, 2, 3), mk(0, 4, 5, 6), 32'h500);
    step("flush_split", 0, 1, 1, 1, mk(0, 1, 2, 3), mk(2, 0, 1, 2), 32'h520);
    step("after_flush", 0, 0, 0, 1, mk(0, 1, 2, 3), mk(2, 0, 1, 2), 32'h600);
    for (int h = 0; h < 3; h++) step("hold", 0, 0, 1, 1, mk(0, 1, 2, 3), mk(1, 0, 1, 2), 32'h700);
    step("hold_release", 0, 0, 0, 0, mk(0, 1, 2, 3), mk(1, 0, 1, 2), 32'h700);
    step("wrap", 0, 0, 0, 1, mk(0, 1, 2, 3), mk(1, 4, 5, 6), 32'hFFFF_FFFC);
    step("wrap_2nd", 0, 0, 0, 1, mk(0, 1, 2, 3), mk(2, 4, 5, 6), 32'h800);
    step("split_hold", 0, 0, 0, 1, mk(2, 1, 2, 3), mk(3, 4, 5, 6), 32'h900);
    step("held_hold", 0, 0, 1, 1, mk(0, 1, 2, 3), mk(2, 4, 5, 6), 32'h920);
    step("held_issue", 0, 0, 0, 1, mk(0, 1, 2, 3), mk(2, 4, 5, 6), 32'h920);
    step("split_rst", 0, 0, 0, 1, mk(0, 1, 2, 3), mk(1, 4, 5, 6), 32'hA00);
    step("rst_in_split", 1, 1, 1, 1, mk(0, 1, 2, 3), mk(1, 4, 5, 6), 32'hA00);
    step("after_rst", 0, 0, 0, 0, mk(0, 1, 2, 3), mk(1, 4, 5, 6), 32'hA00);
    xn = 'x;
    xn[0:10] = 11'b00000000001;
    step("x_nop", 0, 0, 0, 1, xn, mk(2, 0, 1, 2), 32'hB00);
    for (int n = 0; n < 400; n++)
      step("rand", $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
           $urandom_range(0, 3) != 0,
           mk($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
           mk($urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3)),
           $urandom() & ~32'd3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
